line_fill_responder: RTL and testbench

- Memory-side responder for the NPU cache line-fill interface.
- Accepts word-write and line-read requests from the cache controller's memory port.
- Holds a word-addressed backing store.
- Answers each read with a LINE_SIZE-beat burst after a fixed, parameterised access latency.
- Sits between the cache controller and the on-chip scratch/backing memory; benches also use it as the cache's memory model.

---
 rtl/npu_mem_pkg.sv | 17 +
 rtl/line_fill_if.sv | 32 +++
 rtl/npu_word_ram.sv | 26 ++
 rtl/line_fill_responder.sv | 147 ++++++++++++++
 tb/tb_line_fill_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/npu_mem_pkg.sv
`default_nettype none
// npu_mem_pkg : shared encodings and default widths for the NPU memory side (rev 1.0)
package npu_mem_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 16;
  // Shared with the cache controller so both sides agree on burst length.
  localparam int DEF_LINE_SIZE = 4;

  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_WAIT  = 2'd1,
    RSP_BURST = 2'd2
  } rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/line_fill_if.sv
`default_nettype none
// line_fill_if : cache-to-memory line-fill request/response bundle (rev 1.0)
interface line_fill_if
  import npu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEAT_W = $clog2(DEF_LINE_SIZE)
);

  logic              req_ce;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic [BEAT_W-1:0] rsp_beat;

  modport master (
    output req_ce, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_beat
  );

  modport slave (
    input  req_ce, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_beat
  );

endinterface
`default_nettype wire

// File: rtl/npu_word_ram.sv
`default_nettype none
// npu_word_ram : single-port word array, synchronous write, asynchronous read (rev 1.0)
module npu_word_ram #(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int DATA_W      = 16,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/line_fill_responder.sv
`default_nettype none
// line_fill_responder : word-write / line-read memory responder with fixed read latency (rev 1.0)
module line_fill_responder
  import npu_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_SIZE   = DEF_LINE_SIZE,
  parameter int RD_LATENCY  = 2
) (
  input  logic       clk,
  input  logic       rst,
  line_fill_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BEAT_W = $clog2(LINE_SIZE);
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);
  localparam logic [IDX_W-1:0]  LINE_MASK = IDX_W'(LINE_SIZE - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LATENCY - 1);

  rsp_state_t        state, state_d;
  logic [LAT_W-1:0]  lat_cnt, lat_d;
  logic [IDX_W-1:0]  base, base_d;
  logic [BEAT_W-1:0] beat_cnt, beat_d;

  logic              ready_q, valid_q, last_q;
  logic [DATA_W-1:0] rdata_q;
  logic [BEAT_W-1:0] beat_q;
  logic              ready_n, valid_n, last_n;
  logic [DATA_W-1:0] rdata_n;
  logic [BEAT_W-1:0] beat_n;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              accept;
  logic              wr_en;

  assign idx    = bus.req_addr[IDX_W-1:0];
  assign accept = bus.req_ce && ready_q && !rst;
  assign wr_en  = accept && bus.req_we;

  // Upper address bits are deliberately ignored so high addresses alias.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // Read address looks one beat ahead so the registered output lands on time.
  assign ram_addr = wr_en ? idx : (base_d + IDX_W'(beat_d));

  npu_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (bus.req_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RSP_IDLE;
      lat_cnt  <= '0;
      base     <= '0;
      beat_cnt <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      rdata_q  <= '0;
      beat_q   <= '0;
    end else begin
      state    <= state_d;
      lat_cnt  <= lat_d;
      base     <= base_d;
      beat_cnt <= beat_d;
      ready_q  <= ready_n;
      valid_q  <= valid_n;
      last_q   <= last_n;
      rdata_q  <= rdata_n;
      beat_q   <= beat_n;
    end
  end

  always_comb begin
    state_d = state;
    lat_d   = lat_cnt;
    base_d  = base;
    beat_d  = beat_cnt;
    case (state)
      RSP_IDLE: begin
        if (accept && !bus.req_we) begin
          base_d  = idx & ~LINE_MASK;
          beat_d  = '0;
          lat_d   = LAT_LOAD;
          state_d = (RD_LATENCY == 1) ? RSP_BURST : RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        lat_d = lat_cnt - LAT_W'(1);
        if (lat_d == '0) begin
          state_d = RSP_BURST;
        end
      end
      RSP_BURST: begin
        if (beat_cnt == LAST_BEAT) begin
          state_d = RSP_IDLE;
        end else begin
          beat_d = beat_cnt + BEAT_W'(1);
        end
      end
      default: begin
        state_d = RSP_IDLE;
        lat_d   = '0;
        base_d  = '0;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    valid_n = (state_d == RSP_BURST);
    ready_n = (state_d == RSP_IDLE);
    last_n  = valid_n && (beat_d == LAST_BEAT);
    beat_n  = valid_n ? beat_d : '0;
    rdata_n = valid_n ? ram_rdata : rdata_q;
    if (!(state inside {RSP_IDLE, RSP_WAIT, RSP_BURST})) begin
      rdata_n = '0;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_last  = last_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_beat  = beat_q;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_responder.sv
`default_nettype none
// tb_line_fill_responder : directed bench with a cycle-timestamped behavioural model (rev 1.0)
module tb_line_fill_responder;

  localparam int LAT   = 2;
  localparam int LS    = 4;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_fill_if #(.ADDR_W(32), .DATA_W(16), .BEAT_W(2)) bus0 ();
  line_fill_if #(.ADDR_W(32), .DATA_W(16), .BEAT_W(2)) bus1 ();

  line_fill_responder #(
    .ADDR_W(32), .DATA_W(16), .DEPTH_WORDS(DEPTH), .LINE_SIZE(LS), .RD_LATENCY(LAT)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  line_fill_responder #(
    .ADDR_W(32), .DATA_W(16), .DEPTH_WORDS(DEPTH), .LINE_SIZE(LS), .RD_LATENCY(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted read schedules its beats at absolute cycle numbers.
  int          cyc = 0;
  int          ready_from = 0;
  bit          live = 1'b0;
  logic [15:0] store [DEPTH];
  logic [15:0] exp_d [int];
  int          exp_b [int];
  bit          m_ready, m_valid, m_last;
  int          m_beat;
  logic [15:0] m_rdata = '0;

  always @(posedge clk) begin
    int idx, base, n;
    cyc = cyc + 1;
    if (rst) begin
      live = 1'b1;
      exp_d.delete();
      exp_b.delete();
      ready_from = cyc + 1;
      m_rdata = '0;
    end else if (live && bus0.req_ce && cyc >= ready_from) begin
      idx = int'(bus0.req_addr % DEPTH);
      if (bus0.req_we) begin
        store[idx] = bus0.req_wdata;
      end else begin
        base = idx - (idx % LS);
        for (int i = 0; i < LS; i++) begin
          exp_d[cyc + LAT + i] = store[(base + i) % DEPTH];
          exp_b[cyc + LAT + i] = i;
        end
        ready_from = cyc + LAT + LS;
      end
    end
    n = cyc + 1;
    m_ready = (n >= ready_from);
    if (exp_d.exists(n)) begin
      m_valid = 1'b1;
      m_rdata = exp_d[n];
      m_beat  = exp_b[n];
      m_last  = (m_beat == LS - 1);
    end else begin
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_beat  = 0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("m_ready", bus0.req_ready, m_ready);
      chk("m_valid", bus0.rsp_valid, m_valid);
      chk("m_last",  bus0.rsp_last,  m_last);
      chk("m_rdata", bus0.rsp_rdata, m_rdata);
      if (m_valid) chk("m_beat", bus0.rsp_beat, m_beat);
    end
  end

  task automatic cyc0(input bit ce, input bit we, input logic [31:0] a, input logic [15:0] d);
    @(negedge clk);
    bus0.req_ce = ce; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc0(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    cyc0(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc0(1'b1, 1'b0, a, 16'h0);
    idle(LAT + LS - 1);
  endtask

  task automatic cyc1(input bit ce, input bit we, input logic [31:0] a, input logic [15:0] d);
    @(negedge clk);
    bus1.req_ce = ce; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    bus0.req_ce = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_ce = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", bus0.req_ready, 1);
    chk("reset_valid", bus0.rsp_valid, 0);
    chk("reset_rdata", bus0.rsp_rdata, 0);

    wr(32'h40, 16'h1111); wr(32'h41, 16'h2222); wr(32'h42, 16'h3333); wr(32'h43, 16'h4444);

    // Read at 0x42 in cycle T: offset ignored, beats from line 0x40.
    cyc0(1'b1, 1'b0, 32'h42, 16'h0);
    cyc0(1'b0, 1'b0, 32'h0, 16'h0);
    chk("t1_ready", bus0.req_ready, 0);
    chk("t1_valid", bus0.rsp_valid, 0);
    cyc0(1'b0, 1'b0, 32'h0, 16'h0);
    chk("t2_valid", bus0.rsp_valid, 1);
    chk("t2_rdata", bus0.rsp_rdata, 16'h1111);
    chk("t2_beat",  bus0.rsp_beat, 0);
    cyc0(1'b1, 1'b1, 32'h40, 16'hDEAD);
    chk("t3_rdata", bus0.rsp_rdata, 16'h2222);
    chk("t3_last",  bus0.rsp_last, 0);
    cyc0(1'b0, 1'b0, 32'h0, 16'h0);
    chk("t4_rdata", bus0.rsp_rdata, 16'h3333);
    cyc0(1'b0, 1'b0, 32'h0, 16'h0);
    chk("t5_rdata", bus0.rsp_rdata, 16'h4444);
    chk("t5_last",  bus0.rsp_last, 1);
    chk("t5_beat",  bus0.rsp_beat, 3);
    chk("t5_ready", bus0.req_ready, 0);
    // Back-to-back read at the first ready cycle; DEAD write must not have landed.
    cyc0(1'b1, 1'b0, 32'h40, 16'h0);
    chk("t6_ready", bus0.req_ready, 1);
    chk("t6_valid", bus0.rsp_valid, 0);
    chk("t6_hold",  bus0.rsp_rdata, 16'h4444);
    idle(LAT + LS - 1);

    // Address wrap: 0x400 and 0xFFFFFC01 alias words 0 and 1.
    wr(32'h0000_0400, 16'hBEEF); wr(32'hFFFF_FC01, 16'h0101);
    wr(32'h2, 16'h0202); wr(32'h3, 16'h0303);
    cyc0(1'b1, 1'b0, 32'h0, 16'h0);
    idle(1);
    cyc0(1'b0, 1'b0, 32'h0, 16'h0);
    chk("wrap_beat0", bus0.rsp_rdata, 16'hBEEF);
    idle(3);

    for (int i = 0; i < 4; i++) wr(32'h3FC + i, 16'hC000 + 16'(i));
    rd(32'h3FE);
    rd(32'hFFFF_FFFD);

    // Request during WAIT is dropped.
    cyc0(1'b1, 1'b0, 32'h40, 16'h0);
    cyc0(1'b1, 1'b0, 32'h3FC, 16'h0);
    idle(LAT + LS - 2);

    // Reset on the beat-1 cycle, with a write attempt on the same edge.
    cyc0(1'b1, 1'b0, 32'h40, 16'h0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    bus0.req_ce = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h41; bus0.req_wdata = 16'h0BAD;
    chk("rstmid_beat1", bus0.rsp_rdata, 16'h2222);
    @(negedge clk);
    rst = 1'b0;
    bus0.req_ce = 1'b0;
    chk("rstmid_valid", bus0.rsp_valid, 0);
    chk("rstmid_ready", bus0.req_ready, 1);
    idle(3);
    rd(32'h41);
    idle(2);

    // RD_LATENCY=1 instance: beat 0 in the cycle right after accept.
    for (int i = 0; i < 4; i++) cyc1(1'b1, 1'b1, 32'h10 + i, 16'hA5A0 + 16'(i));
    cyc1(1'b1, 1'b0, 32'h13, 16'h0);
    cyc1(1'b0, 1'b0, 32'h0, 16'h0);
    chk("lat1_t1_valid", bus1.rsp_valid, 1);
    chk("lat1_t1_rdata", bus1.rsp_rdata, 16'hA5A0);
    chk("lat1_t1_beat",  bus1.rsp_beat, 0);
    chk("lat1_t1_ready", bus1.req_ready, 0);
    cyc1(1'b0, 1'b0, 32'h0, 16'h0);
    chk("lat1_t2_rdata", bus1.rsp_rdata, 16'hA5A1);
    cyc1(1'b0, 1'b0, 32'h0, 16'h0);
    chk("lat1_t3_last",  bus1.rsp_last, 0);
    cyc1(1'b0, 1'b0, 32'h0, 16'h0);
    chk("lat1_t4_last",  bus1.rsp_last, 1);
    chk("lat1_t4_rdata", bus1.rsp_rdata, 16'hA5A3);
    cyc1(1'b0, 1'b0, 32'h0, 16'h0);
    chk("lat1_t5_ready", bus1.req_ready, 1);
    chk("lat1_t5_valid", bus1.rsp_valid, 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
